// File: rtl/emu_transactor_gen2_if.sv
// Host byte channel of the co-emulation transactor: write/command strobes in,
// registered read data and busy flag out.
interface emu_transactor_gen2_if #(
  parameter int ADDR_W = 4
);
  logic [7:0]        Din_emu;
  logic [ADDR_W-1:0] Addr_emu;
  logic              wr_emu;
  logic              load_emu;
  logic              get_emu;
  logic              step_emu;
  logic [7:0]        Dout_emu;
  logic              busy_emu;

  modport master (
    output Din_emu, Addr_emu, wr_emu, load_emu, get_emu, step_emu,
    input  Dout_emu, busy_emu
  );

  modport slave (
    input  Din_emu, Addr_emu, wr_emu, load_emu, get_emu, step_emu,
    output Dout_emu, busy_emu
  );
endinterface

// File: rtl/emu_transactor_gen2.sv
// Co-emulation transactor: double-buffered stimulus, capture bank, step engine.
// Optional EMU_AUTO_CAPTURE_EN: capture out_bus automatically at the end of a step.
//
// state     | meaning
// S_IDLE    | accepting host commands
// S_RUN     | clk_dut_en high, down-counter running
// S_CAPTURE | one cycle sampling out_bus into the capture bank (auto-capture only)
module emu_transactor_gen2 #(
  parameter int STIM_BYTES = 8,
  parameter int OUT_BYTES  = 8,
  parameter int ADDR_W     = 4,
  parameter int STEP_W     = 16
) (
  input  logic                    clk_emu,
  input  logic                    reset,
  emu_transactor_gen2_if.slave    host,
  output logic [8*STIM_BYTES-1:0] stim_bus,
  input  logic [8*OUT_BYTES-1:0]  out_bus,
  output logic                    clk_dut_en
);
  localparam logic [ADDR_W-1:0] A_STEP_LO = ADDR_W'(STIM_BYTES);
  localparam logic [ADDR_W-1:0] A_STEP_HI = ADDR_W'(STIM_BYTES + 1);
  localparam logic [ADDR_W-1:0] A_STATUS  = ADDR_W'(OUT_BYTES);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_CAPTURE} state_t;

  state_t                  r_state, w_next;
  logic                    r_busy;
  logic [8*STIM_BYTES-1:0] r_shadow, r_stim;
  logic [8*OUT_BYTES-1:0]  r_capture;
  logic [STEP_W-1:0]       r_step_cnt, r_down;
  logic                    r_dut_en, r_done, r_err, r_zero_pend;
  logic [7:0]              r_dout, w_rd_byte;
  logic                    w_idle, w_cmd_any, w_do_load, w_do_get, w_do_step, w_do_wr;
  logic                    w_step_zero, w_run_last, w_done_set, w_err_set, w_rd_status;
  logic                    w_zero_set;

  assign w_idle      = (r_state == S_IDLE);
  assign w_cmd_any   = host.wr_emu | host.load_emu | host.get_emu | host.step_emu;
  assign w_do_load   = w_idle & host.load_emu;
  assign w_do_get    = w_idle & ~host.load_emu & host.get_emu;
  assign w_do_step   = w_idle & ~host.load_emu & ~host.get_emu & host.step_emu;
  assign w_do_wr     = w_idle & ~host.load_emu & ~host.get_emu & ~host.step_emu & host.wr_emu;
  assign w_step_zero = (r_step_cnt == '0);
  assign w_run_last  = (r_state == S_RUN) && (r_down == STEP_W'(1));
  assign w_err_set   = r_busy & w_cmd_any;
  assign w_rd_status = (host.Addr_emu == A_STATUS);

`ifdef EMU_AUTO_CAPTURE_EN
  assign w_zero_set = 1'b0;
`else
  assign w_zero_set = w_do_step & w_step_zero;
`endif

  always_comb begin
    w_next     = r_state;
    w_done_set = r_zero_pend;
    unique case (r_state)
      S_IDLE: begin
        if (w_do_step && !w_step_zero) w_next = S_RUN;
`ifdef EMU_AUTO_CAPTURE_EN
        else if (w_do_step) w_next = S_CAPTURE;
`endif
      end
      S_RUN: begin
        if (w_run_last) begin
`ifdef EMU_AUTO_CAPTURE_EN
          w_next = S_CAPTURE;
`else
          w_next     = S_IDLE;
          w_done_set = 1'b1;
`endif
        end
      end
      S_CAPTURE: begin
        w_next     = S_IDLE;
        w_done_set = 1'b1;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_emu) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next != S_IDLE);
    end
  end

  always_comb begin
    w_rd_byte = 8'h00;
    for (int k = 0; k < OUT_BYTES; k++)
      if (host.Addr_emu == ADDR_W'(k)) w_rd_byte = r_capture[8*k +: 8];
    if (w_rd_status) w_rd_byte = {5'b0, r_done, r_err, r_busy};
  end

  always_ff @(posedge clk_emu) begin
    if (reset) begin
      r_shadow    <= '0;
      r_stim      <= '0;
      r_capture   <= '0;
      r_step_cnt  <= '0;
      r_down      <= '0;
      r_dut_en    <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_zero_pend <= 1'b0;
      r_dout      <= 8'h00;
    end else begin
      if (w_do_wr) begin
        for (int k = 0; k < STIM_BYTES; k++)
          if (host.Addr_emu == ADDR_W'(k)) r_shadow[8*k +: 8] <= host.Din_emu;
        if (host.Addr_emu == A_STEP_LO) r_step_cnt[7:0]  <= host.Din_emu;
        if (host.Addr_emu == A_STEP_HI) r_step_cnt[15:8] <= host.Din_emu;
      end
      if (w_do_load) r_stim <= r_shadow;
      if (w_do_get || r_state == S_CAPTURE) r_capture <= out_bus;
      // r_step_cnt is left intact so the same step can be reissued
      if (w_do_step && !w_step_zero) begin
        r_down   <= r_step_cnt;
        r_dut_en <= 1'b1;
      end else if (r_state == S_RUN) begin
        r_down <= r_down - STEP_W'(1);
        if (w_run_last) r_dut_en <= 1'b0;
      end
      r_zero_pend <= w_zero_set;
      r_dout      <= w_rd_byte;
      r_done      <= w_done_set | (r_done & ~w_rd_status);
      r_err       <= w_err_set  | (r_err  & ~w_rd_status);
    end
  end

  assign stim_bus      = r_stim;
  assign clk_dut_en    = r_dut_en;
  assign host.Dout_emu = r_dout;
  assign host.busy_emu = r_busy;
endmodule

// File: tb/tb_emu_transactor_gen2.sv
// Directed bench for emu_transactor_gen2 with a byte counter standing in for the DUT.
// Works with or without EMU_AUTO_CAPTURE_EN defined.
module tb_emu_transactor_gen2;
  logic        clk_emu = 1'b0;
  logic        reset;
  logic [63:0] stim_bus;
  logic [63:0] out_bus;
  logic        clk_dut_en;
  logic [7:0]  dut_cnt;
  logic [55:0] out_hi;
  logic        cnt_load;
  logic [7:0]  cnt_init;
  int          tests = 0;
  int          fails = 0;

  emu_transactor_gen2_if #(.ADDR_W(4)) host_if ();

  emu_transactor_gen2 #(
    .STIM_BYTES(8), .OUT_BYTES(8), .ADDR_W(4), .STEP_W(16)
  ) dut (
    .clk_emu   (clk_emu),
    .reset     (reset),
    .host      (host_if),
    .stim_bus  (stim_bus),
    .out_bus   (out_bus),
    .clk_dut_en(clk_dut_en)
  );

  always #5 clk_emu = ~clk_emu;

  // stand-in DUT: byte counter advancing on each enabled clock
  always @(posedge clk_emu) begin
    if (cnt_load) dut_cnt <= cnt_init;
    else if (clk_dut_en) dut_cnt <= dut_cnt + 8'd1;
  end
  assign out_bus = {out_hi, dut_cnt};

  task automatic tick();
    @(posedge clk_emu);
    #1;
  endtask

  task automatic rd(input logic [3:0] a, output logic [7:0] d);
    host_if.Addr_emu = a;
    tick();
    d = host_if.Dout_emu;
    host_if.Addr_emu = 4'hF;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] v);
    host_if.Addr_emu = a;
    host_if.Din_emu  = v;
    host_if.wr_emu   = 1'b1;
    tick();
    host_if.wr_emu   = 1'b0;
    host_if.Addr_emu = 4'hF;
  endtask

  task automatic pulse_step();
    host_if.step_emu = 1'b1;
    tick();
    host_if.step_emu = 1'b0;
  endtask

  task automatic pulse_load();
    host_if.load_emu = 1'b1;
    tick();
    host_if.load_emu = 1'b0;
  endtask

  task automatic pulse_get();
    host_if.get_emu = 1'b1;
    tick();
    host_if.get_emu = 1'b0;
  endtask

  task automatic set_cnt(input logic [7:0] v);
    cnt_init = v;
    cnt_load = 1'b1;
    tick();
    cnt_load = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] d;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    for (int a = 0; a <= 8; a++) begin
      rd(4'(a), d);
      tests++;
      if (d !== 8'h00) begin
        fails++;
        $display("FAIL reset_read[%0d]: got %h expected 00", a, d);
      end
    end
    tests++;
    if (clk_dut_en !== 1'b0 || host_if.busy_emu !== 1'b0 || stim_bus !== 64'h0) begin
      fails++;
      $display("FAIL reset_outputs: en=%b busy=%b stim=%h expected 0/0/0", clk_dut_en, host_if.busy_emu, stim_bus);
    end
  endtask

  task automatic test_load();
    wr(4'd0, 8'hA5);
    wr(4'd7, 8'h3C);
    tests++;
    if (stim_bus !== 64'h0) begin
      fails++;
      $display("FAIL stim_before_load: got %h expected 0", stim_bus);
    end
    pulse_load();
    tests++;
    if (stim_bus !== 64'h3C00_0000_0000_00A5) begin
      fails++;
      $display("FAIL stim_after_load: got %h expected 3c000000000000a5", stim_bus);
    end
  endtask

  task automatic test_step();
    logic [7:0] d;
    int cnt;
    wr(4'd8, 8'h03);
    wr(4'd9, 8'h00);
    pulse_step();
    tests++;
    if (clk_dut_en !== 1'b1 || host_if.busy_emu !== 1'b1) begin
      fails++;
      $display("FAIL step_start: en=%b busy=%b expected 1/1", clk_dut_en, host_if.busy_emu);
    end
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (clk_dut_en === 1'b1) cnt++;
      tick();
    end
    tests++;
    if (cnt != 3) begin
      fails++;
      $display("FAIL step_pulses: got %0d expected 3", cnt);
    end
    rd(4'd8, d);
    tests++;
    if (d !== 8'h04) begin
      fails++;
      $display("FAIL step_status_done: got %h expected 04", d);
    end
    rd(4'd8, d);
    tests++;
    if (d !== 8'h00) begin
      fails++;
      $display("FAIL step_status_cleared: got %h expected 00", d);
    end
  endtask

  task automatic test_step_zero();
    logic [7:0] d;
    int cnt;
    wr(4'd8, 8'h00);
    cnt = 0;
    pulse_step();
    if (clk_dut_en === 1'b1) cnt++;
    tick();
    if (clk_dut_en === 1'b1) cnt++;
    tests++;
    if (cnt != 0) begin
      fails++;
      $display("FAIL zero_step_pulses: got %0d expected 0", cnt);
    end
    rd(4'd8, d);
    tests++;
    if (d !== 8'h04) begin
      fails++;
      $display("FAIL zero_step_done: got %h expected 04", d);
    end
  endtask

  task automatic test_busy_err();
    logic [7:0] d;
    int cnt;
    wr(4'd8, 8'h04);
    cnt = 0;
    pulse_step();
    if (clk_dut_en === 1'b1) cnt++;
    pulse_step();
    if (clk_dut_en === 1'b1) cnt++;
    wr(4'd0, 8'hFF);
    for (int i = 0; i < 10; i++) begin
      if (clk_dut_en === 1'b1) cnt++;
      tick();
    end
    tests++;
    if (cnt != 4) begin
      fails++;
      $display("FAIL busy_pulses: got %0d expected 4", cnt);
    end
    rd(4'd8, d);
    tests++;
    if (d !== 8'h06) begin
      fails++;
      $display("FAIL busy_status_err: got %h expected 06", d);
    end
    rd(4'd8, d);
    tests++;
    if (d !== 8'h00) begin
      fails++;
      $display("FAIL busy_status_cleared: got %h expected 00", d);
    end
    pulse_load();
    tests++;
    if (stim_bus !== 64'h3C00_0000_0000_00A5) begin
      fails++;
      $display("FAIL busy_shadow_kept: got %h expected 3c000000000000a5", stim_bus);
    end
  endtask

  task automatic test_priority();
    logic [7:0] d;
    out_hi = 56'h11_2233_4455_6677;
    set_cnt(8'h42);
    pulse_get();
    rd(4'd1, d);
    tests++;
    if (d !== 8'h77) begin
      fails++;
      $display("FAIL get_byte1: got %h expected 77", d);
    end
    out_hi = 56'hAA_AAAA_AAAA_AAAA;
    set_cnt(8'h99);
    wr(4'd1, 8'h5A);
    host_if.load_emu = 1'b1;
    host_if.get_emu  = 1'b1;
    tick();
    host_if.load_emu = 1'b0;
    host_if.get_emu  = 1'b0;
    tests++;
    if (stim_bus !== 64'h3C00_0000_0000_5AA5) begin
      fails++;
      $display("FAIL prio_load: got %h expected 3c00000000005aa5", stim_bus);
    end
    rd(4'd1, d);
    tests++;
    if (d !== 8'h77) begin
      fails++;
      $display("FAIL prio_capture1: got %h expected 77", d);
    end
    rd(4'd0, d);
    tests++;
    if (d !== 8'h42) begin
      fails++;
      $display("FAIL prio_capture0: got %h expected 42", d);
    end
  endtask

  task automatic test_auto_capture();
    logic [7:0] d;
    int guard;
    set_cnt(8'h10);
    wr(4'd8, 8'h05);
    pulse_step();
    guard = 0;
    while (host_if.busy_emu === 1'b1 && guard < 30) begin
      tick();
      guard++;
    end
    tests++;
    if (guard >= 30) begin
      fails++;
      $display("FAIL run_timeout: busy=%b expected 0 within 30 cycles", host_if.busy_emu);
    end
`ifndef EMU_AUTO_CAPTURE_EN
    rd(4'd0, d);
    tests++;
    if (d !== 8'h42) begin
      fails++;
      $display("FAIL no_auto_capture: got %h expected 42", d);
    end
    pulse_get();
`endif
    rd(4'd0, d);
    tests++;
    if (d !== 8'h15) begin
      fails++;
      $display("FAIL capture_after_run: got %h expected 15", d);
    end
  endtask

  task automatic test_reset_in_run();
    logic [7:0] d;
    wr(4'd8, 8'h05);
    pulse_step();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tests++;
    if (clk_dut_en !== 1'b0 || host_if.busy_emu !== 1'b0 || stim_bus !== 64'h0) begin
      fails++;
      $display("FAIL reset_in_run: en=%b busy=%b stim=%h expected 0/0/0", clk_dut_en, host_if.busy_emu, stim_bus);
    end
    rd(4'd8, d);
    tests++;
    if (d !== 8'h00) begin
      fails++;
      $display("FAIL reset_in_run_status: got %h expected 00", d);
    end
  endtask

  initial begin
    reset            = 1'b1;
    host_if.Din_emu  = 8'h00;
    host_if.Addr_emu = 4'hF;
    host_if.wr_emu   = 1'b0;
    host_if.load_emu = 1'b0;
    host_if.get_emu  = 1'b0;
    host_if.step_emu = 1'b0;
    out_hi           = 56'h0;
    cnt_init         = 8'h00;
    cnt_load         = 1'b1;
    test_reset();
    cnt_load = 1'b0;
    test_load();
    test_step();
    test_step_zero();
    test_busy_err();
    test_priority();
    test_auto_capture();
    test_reset_in_run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
